// File: rtl/rom_stream_reader_pkg.sv
// Shared definitions for the ROM stream reader: FSM encoding and the
// dimensions of the read-latency FIFO.
package rom_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH = 3;

  // Circular pointer advance over a non-power-of-2 depth.
  function automatic logic [1:0] fifo_ptr_next(input logic [1:0] ptr);
    return (ptr == 2'(FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/rom_stream_reader_fifo.sv
// Three-entry first-word-fall-through FIFO absorbing ROM read latency and
// downstream backpressure. Synchronous active-low reset.
module rom_rd_fifo
  import rom_stream_reader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [WORD_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [1:0]            rd_ptr;
  logic [1:0]            wr_ptr;
  logic                  pop_ok;
  logic                  push_ok;

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'(FIFO_DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= fifo_ptr_next(wr_ptr);
      if (pop_ok)  rd_ptr <= fifo_ptr_next(rd_ptr);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// Streams LENGTH consecutive ROM words from a base address onto a
// valid/ready interface, with wrap at LINES and a last-word flag.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned WORD_WIDTH    = 24,
  parameter int unsigned LINES         = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  output logic                     rom_read_en,
  input  logic [WORD_WIDTH-1:0]    rom_data,
  output logic [WORD_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(LINES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE   = (ADDRESS_WIDTH + 1)'(1);

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH:0]   issue_cnt;
  logic [ADDRESS_WIDTH:0]   recv_cnt;
  logic                     rd_prev;
  logic [1:0]               fifo_count;
  logic                     credit_ok;
  logic                     pop;
  logic                     accept;
  logic                     empty_start;
  logic                     last_issue;
  logic                     last_pop;

  rom_rd_fifo #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_prev),
    .push_data (rom_data),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count)
  );

  // Words already held plus the one arriving this cycle must leave room for
  // the read being issued; registered terms only, so no path from out_ready.
  assign credit_ok   = ({1'b0, fifo_count} + {2'b00, rd_prev}) <= 3'd2;
  assign out_valid   = (fifo_count != 2'd0);
  assign pop         = out_valid && out_ready;
  assign accept      = (state == IDLE) && start && (length != '0);
  assign empty_start = (state == IDLE) && start && (length == '0);
  assign last_issue  = rom_read_en && (issue_cnt == CNT_ONE);
  assign last_pop    = pop && (recv_cnt == CNT_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)     state_next = FETCH;
      FETCH:   if (last_issue) state_next = DRAIN;
      DRAIN:   if (last_pop)   state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    rom_read_en = (state == FETCH) && (issue_cnt != '0) && credit_ok;
    out_last    = out_valid && (recv_cnt == CNT_ONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_address <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      rd_prev     <= 1'b0;
      done        <= 1'b0;
    end else begin
      rd_prev <= rom_read_en;
      done    <= empty_start || ((state == DRAIN) && last_pop);
      if (accept) begin
        rom_address <= base_addr;
        issue_cnt   <= length;
        recv_cnt    <= length;
      end else begin
        if (rom_read_en) begin
          issue_cnt   <= issue_cnt - CNT_ONE;
          rom_address <= (rom_address == LAST_ADDR) ? '0 : rom_address + ADDR_ONE;
        end
        if (pop) begin
          recv_cnt <= recv_cnt - CNT_ONE;
        end
      end
    end
  end

endmodule
